// File: rtl/pipelined_mag_comparator.sv
// Two-stage registered magnitude comparator.
// Stage 1 compares the upper and lower operand halves independently; stage 2
// merges them, with the upper half deciding and the lower half breaking ties.
// Define CMP_SIGNED_EN to compare two's-complement operands instead of unsigned.
// Handshake: in_valid qualifies a_in/b_in on the rising edge it is sampled;
// out_valid qualifies lt/eq/gt exactly two edges later. There is no ready or
// backpressure: every qualified pair yields one result, in order.
module pipelined_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int HW = WIDTH / 2;

  // Stage-1 state
  logic hi_lt_q, hi_eq_q, hi_gt_q;
  logic lo_lt_q, lo_eq_q, lo_gt_q;
  logic s1_valid_q;

  // Stage-2 state
  logic lt_q, eq_q, gt_q;
  logic out_valid_q;

  // Operands as seen by the half comparators
  logic [WIDTH-1:0] a_adj, b_adj;
  logic hi_lt_d, hi_eq_d, hi_gt_d;
  logic lo_lt_d, lo_eq_d, lo_gt_d;

`ifdef CMP_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    a_adj          = a_in;
    b_adj          = b_in;
    a_adj[WIDTH-1] = ~a_in[WIDTH-1];
    b_adj[WIDTH-1] = ~b_in[WIDTH-1];
  end
`else
  // Unsigned compare uses the operands unchanged.
  always_comb begin
    a_adj = a_in;
    b_adj = b_in;
  end
`endif

  // Per-half priority compare; walking LSB to MSB makes the MSB dominate.
  always_comb begin
    logic lt_b, gt_b, eq_b;
    hi_lt_d = 1'b0;
    hi_gt_d = 1'b0;
    hi_eq_d = 1'b1;
    lo_lt_d = 1'b0;
    lo_gt_d = 1'b0;
    lo_eq_d = 1'b1;
    for (int i = 0; i < HW; i++) begin
      lt_b    = ~a_adj[i] & b_adj[i];
      gt_b    = a_adj[i] & ~b_adj[i];
      eq_b    = ~(lt_b | gt_b);
      lo_lt_d = lt_b | (eq_b & lo_lt_d);
      lo_gt_d = gt_b | (eq_b & lo_gt_d);
      lo_eq_d = lo_eq_d & eq_b;
    end
    for (int i = HW; i < WIDTH; i++) begin
      lt_b    = ~a_adj[i] & b_adj[i];
      gt_b    = a_adj[i] & ~b_adj[i];
      eq_b    = ~(lt_b | gt_b);
      hi_lt_d = lt_b | (eq_b & hi_lt_d);
      hi_gt_d = gt_b | (eq_b & hi_gt_d);
      hi_eq_d = hi_eq_d & eq_b;
    end
  end

  // Stage 1: capture half results on valid input; valid bit tracks every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_lt_q    <= 1'b0;
      hi_eq_q    <= 1'b0;
      hi_gt_q    <= 1'b0;
      lo_lt_q    <= 1'b0;
      lo_eq_q    <= 1'b0;
      lo_gt_q    <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        hi_lt_q <= hi_lt_d;
        hi_eq_q <= hi_eq_d;
        hi_gt_q <= hi_gt_d;
        lo_lt_q <= lo_lt_d;
        lo_eq_q <= lo_eq_d;
        lo_gt_q <= lo_gt_d;
      end
    end
  end

  // Stage 2: merge halves; flags hold across bubbles, out_valid does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        lt_q <= hi_lt_q | (hi_eq_q & lo_lt_q);
        gt_q <= hi_gt_q | (hi_eq_q & lo_gt_q);
        eq_q <= hi_eq_q & lo_eq_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign gt        = gt_q;

endmodule

// File: tb/tb_pipelined_mag_comparator.sv
// Directed bench for pipelined_mag_comparator (WIDTH=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pipelined_mag_comparator;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         lt;
  logic         eq;
  logic         gt;

  int total;
  int bad;

  // Expected {lt,eq,gt} codes
  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  pipelined_mag_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a_in     = '0;
    b_in     = '0;
  end

  // Driver task: present one pair (or a bubble) until the next falling edge.
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = v;
    a_in     = a;
    b_in     = b;
  endtask

  task automatic test_reset;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, lt, eq, gt} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_async: got ov/lt/eq/gt=%b want 0000", {out_valid, lt, eq, gt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, lt, eq, gt} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_idle_%0d: got %b want 0000", i, {out_valid, lt, eq, gt});
      end
    end
  endtask

  task automatic test_equality;
    drive(1'b1, 8'h5A, 8'h5A);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL eq_latency1: out_valid=%b want 0 after one edge", out_valid);
    end
    @(negedge clk);
    total++;
    if ({out_valid, lt, eq, gt} !== {1'b1, R_EQ}) begin
      bad++;
      $display("FAIL eq_result: got %b want 1010", {out_valid, lt, eq, gt});
    end
    @(negedge clk);
    total++;
    if ({out_valid, lt, eq, gt} !== {1'b0, R_EQ}) begin
      bad++;
      $display("FAIL eq_hold: got %b want 0010", {out_valid, lt, eq, gt});
    end
  endtask

  task automatic test_single_pairs;
    // a, b, expected {lt,eq,gt} for the active build
    logic [W-1:0] av [7];
    logic [W-1:0] bv [7];
    logic [2:0]   ev [7];
    av[0] = 8'h1F; bv[0] = 8'h21; ev[0] = R_LT;  // upper half decides
    av[1] = 8'h90; bv[1] = 8'h8F; ev[1] = R_GT;  // upper decides though lower says lt
    av[2] = 8'h00; bv[2] = 8'h00; ev[2] = R_EQ;
    av[3] = 8'h10; bv[3] = 8'h0F; ev[3] = R_GT;  // upper overrides lower
    av[4] = 8'hFF; bv[4] = 8'hFE; ev[4] = R_GT;
`ifdef CMP_SIGNED_EN
    av[5] = 8'h80; bv[5] = 8'h7F; ev[5] = R_LT;  // -128 < 127
    av[6] = 8'h01; bv[6] = 8'hF0; ev[6] = R_GT;  // 1 > -16
`else
    av[5] = 8'h80; bv[5] = 8'h7F; ev[5] = R_GT;
    av[6] = 8'h01; bv[6] = 8'hF0; ev[6] = R_LT;
`endif
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, av[i], bv[i]);
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00);
      @(negedge clk);
      total++;
      if ({out_valid, lt, eq, gt} !== {1'b1, ev[i]}) begin
        bad++;
        $display("FAIL pair_%0d a=%h b=%h: got %b want %b", i, av[i], bv[i],
                 {out_valid, lt, eq, gt}, {1'b1, ev[i]});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] exp_q_a [4];
    logic [W-1:0] exp_q_b [4];
    logic [2:0]   exp_q [$];
    logic [2:0]   want;
    exp_q_a[0] = 8'h37; exp_q_b[0] = 8'h35;
    exp_q_a[1] = 8'h35; exp_q_b[1] = 8'h37;
    exp_q_a[2] = 8'hFF; exp_q_b[2] = 8'h00;
    exp_q_a[3] = 8'h00; exp_q_b[3] = 8'hFF;
    exp_q.push_back(R_GT);
    exp_q.push_back(R_LT);
`ifdef CMP_SIGNED_EN
    exp_q.push_back(R_LT);  // -1 < 0
    exp_q.push_back(R_GT);
`else
    exp_q.push_back(R_GT);
    exp_q.push_back(R_LT);
`endif
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        want = exp_q.pop_front();
        total++;
        if ({out_valid, lt, eq, gt} !== {1'b1, want}) begin
          bad++;
          $display("FAIL b2b_%0d: got %b want %b", i - 2, {out_valid, lt, eq, gt}, {1'b1, want});
        end
      end
      if (i < 4) drive(1'b1, exp_q_a[i], exp_q_b[i]);
      else       drive(1'b0, 8'h00, 8'h00);
      @(negedge clk);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream;
    drive(1'b1, 8'h12, 8'h34);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00);
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, lt, eq, gt} !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_now: got %b want 0000", {out_valid, lt, eq, gt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, lt, eq, gt} !== 4'b0000) begin
        bad++;
        $display("FAIL midrst_after_%0d: got %b want 0000", i, {out_valid, lt, eq, gt});
      end
    end
    // First post-reset pair appears exactly two edges later
    drive(1'b1, 8'h34, 8'h12);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_early: out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    total++;
    if ({out_valid, lt, eq, gt} !== {1'b1, R_GT}) begin
      bad++;
      $display("FAIL midrst_first: got %b want 1001", {out_valid, lt, eq, gt});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_equality();
    test_single_pairs();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog keeps the run bounded.
  initial begin
    #20000;
    $display("FAIL watchdog: timeout reached, want finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
